// File: rtl/spad_access_ctrl.sv
// Round-robin read/write arbitration in front of a 1R1W scratchpad.
// Define RAW_BYPASS_EN to forward write data to a colliding read instead of stalling it.
module spad_access_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 rd_valid,
  input  logic [NUM_REQ*ADDR_BITWIDTH-1:0]   rd_addr,
  output logic [NUM_REQ-1:0]                 rd_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_BITWIDTH-1:0]           rsp_data,
  input  logic [NUM_REQ-1:0]                 wr_valid,
  input  logic [NUM_REQ*ADDR_BITWIDTH-1:0]   wr_addr,
  input  logic [NUM_REQ*DATA_BITWIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]                 wr_ready,
  output logic                               spad_read_req,
  output logic [ADDR_BITWIDTH-1:0]           spad_r_addr,
  output logic                               spad_write_en,
  output logic [ADDR_BITWIDTH-1:0]           spad_w_addr,
  output logic [DATA_BITWIDTH-1:0]           spad_w_data,
  input  logic [DATA_BITWIDTH-1:0]           spad_r_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [IW-1:0]            rd_g, wr_g;
  logic                     rd_any, wr_any;
  logic [ADDR_BITWIDTH-1:0] rd_a_g, wr_a_g;
  logic [DATA_BITWIDTH-1:0] wr_d_g;
  logic                     coll, rd_go, rd_mem, wr_go;

  // Scan from p upward with wrap; lowest distance from p wins.
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      p
  );
    logic [IW:0] res;
    logic [IW:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, p} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ))
        idx = idx - (IW+1)'(NUM_REQ);
      if (v[idx[IW-1:0]])
        res = {1'b1, idx[IW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
  endfunction

  always_comb begin
    {rd_any, rd_g} = rr_pick(rd_valid, rd_ptr_q);
    {wr_any, wr_g} = rr_pick(wr_valid, wr_ptr_q);
  end

  assign rd_a_g = rd_addr[rd_g*ADDR_BITWIDTH +: ADDR_BITWIDTH];
  assign wr_a_g = wr_addr[wr_g*ADDR_BITWIDTH +: ADDR_BITWIDTH];
  assign wr_d_g = wr_data[wr_g*DATA_BITWIDTH +: DATA_BITWIDTH];
  assign coll   = rd_any & wr_any & (rd_a_g == wr_a_g);
  assign wr_go  = wr_any & ~reset;

`ifdef RAW_BYPASS_EN
  assign rd_go  = rd_any & ~reset;
  assign rd_mem = rd_go & ~coll;
`else
  assign rd_go  = rd_any & ~coll & ~reset;
  assign rd_mem = rd_go;
`endif

  assign rd_ready      = rd_go ? (NUM_REQ'(1) << rd_g) : '0;
  assign wr_ready      = wr_go ? (NUM_REQ'(1) << wr_g) : '0;
  assign spad_read_req = rd_mem;
  assign spad_r_addr   = rd_a_g;
  assign spad_write_en = wr_go;
  assign spad_w_addr   = wr_a_g;
  assign spad_w_data   = wr_d_g;
  assign rsp_valid     = rsp_valid_q;

  assign rd_ptr_d = rd_go ? nxt(rd_g) : rd_ptr_q;
  assign wr_ptr_d = wr_go ? nxt(wr_g) : wr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rd_ready;
    end
  end

`ifdef RAW_BYPASS_EN
  logic                     byp_sel_q, byp_sel_d;
  logic [DATA_BITWIDTH-1:0] byp_q, byp_d;

  assign byp_sel_d = rd_go & coll;
  assign byp_d     = byp_sel_d ? wr_d_g : byp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      byp_sel_q <= byp_sel_d;
      byp_q     <= byp_d;
    end
  end

  assign rsp_data = byp_sel_q ? byp_q : spad_r_data;
`else
  assign rsp_data = spad_r_data;
`endif

endmodule

// File: tb/tb_spad_access_ctrl.sv
// Bench for spad_access_ctrl: scratchpad model, reference model checker, directed tests.
// Honours RAW_BYPASS_EN to select the expected collision behaviour.
module tb_spad_access_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 10;
`ifdef RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rd_valid, rd_ready, rsp_valid, wr_valid, wr_ready;
  logic [N*AW-1:0] rd_addr, wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [DW-1:0]   rsp_data, spad_w_data, spad_r_data;
  logic            spad_read_req, spad_write_en;
  logic [AW-1:0]   spad_r_addr, spad_w_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spad_access_ctrl #(.NUM_REQ(N), .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .spad_read_req(spad_read_req), .spad_r_addr(spad_r_addr),
    .spad_write_en(spad_write_en), .spad_w_addr(spad_w_addr),
    .spad_w_data(spad_w_data), .spad_r_data(spad_r_data)
  );

  // Scratchpad: 1-cycle registered read, write lands at the edge.
  logic [DW-1:0] smem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (spad_write_en) smem[spad_w_addr] <= spad_w_data;
    if (spad_read_req) spad_r_data <= smem[spad_r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int best, bd, d;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - p + N) % N;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // Reference model, checked every cycle at the falling edge.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_rptr, m_wptr, m_pend;
  logic [DW-1:0] m_pdata;

  always @(negedge clk) begin
    int wg, rg;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    bit col, acc;
    if (reset) begin
      chk("m_rst_rd_ready", 32'(rd_ready), 0);
      chk("m_rst_wr_ready", 32'(wr_ready), 0);
      chk("m_rst_re", 32'(spad_read_req), 0);
      chk("m_rst_we", 32'(spad_write_en), 0);
      chk("m_rst_rsp_valid", 32'(rsp_valid), 0);
      m_rptr = 0;
      m_wptr = 0;
      m_pend = -1;
    end else begin
      if (m_pend >= 0) begin
        chk("m_rsp_valid", 32'(rsp_valid), 32'(1 << m_pend));
        chk("m_rsp_data", 32'(rsp_data), 32'(m_pdata));
      end else begin
        chk("m_rsp_idle", 32'(rsp_valid), 0);
      end
      wg = pick(wr_valid, m_wptr);
      rg = pick(rd_valid, m_rptr);
      wa = '0; ra = '0; wd = '0;
      if (wg >= 0) begin
        wa = wr_addr[wg*AW +: AW];
        wd = wr_data[wg*DW +: DW];
      end
      if (rg >= 0) ra = rd_addr[rg*AW +: AW];
      col = (wg >= 0) && (rg >= 0) && (wa == ra);
      acc = (rg >= 0) && (!col || BYP);
      chk("m_wr_ready", 32'(wr_ready), (wg >= 0) ? 32'(1 << wg) : 0);
      chk("m_we", 32'(spad_write_en), 32'(wg >= 0));
      if (wg >= 0) begin
        chk("m_w_addr", 32'(spad_w_addr), 32'(wa));
        chk("m_w_data", 32'(spad_w_data), 32'(wd));
      end
      chk("m_rd_ready", 32'(rd_ready), acc ? 32'(1 << rg) : 0);
      chk("m_re", 32'(spad_read_req), 32'((rg >= 0) && !col));
      if ((rg >= 0) && !col) chk("m_r_addr", 32'(spad_r_addr), 32'(ra));
      m_pend  = acc ? rg : -1;
      m_pdata = col ? wd : ref_mem[ra];
      if (wg >= 0) begin
        ref_mem[wa] = wd;
        m_wptr = (wg + 1) % N;
      end
      if (acc) m_rptr = (rg + 1) % N;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int r, input int a, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    wr_valid[r] = 1'b1;
    wr_addr[r*AW +: AW] = AW'(a);
    wr_data[r*DW +: DW] = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (wr_ready[r]) ok = 1;
      else tick();
    end
    chk("wr_handshake", 32'(ok), 1);
    tick();
    wr_valid[r] = 1'b0;
  endtask

  task automatic do_read(input int r, input int a, output logic [DW-1:0] d);
    bit ok;
    ok = 0;
    rd_valid[r] = 1'b1;
    rd_addr[r*AW +: AW] = AW'(a);
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (rd_ready[r]) ok = 1;
      else tick();
    end
    chk("rd_handshake", 32'(ok), 1);
    tick();
    rd_valid[r] = 1'b0;
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid[r]), 1);
    d = rsp_data;
    tick();
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 1'b1;
    rd_valid = '0; wr_valid = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) do_write(0, i, DW'(16'h100 + i));
    do_write(0, 5, 16'h0555);
    do_write(0, 7, 16'h1111);

    // 1: reset in the middle of a read
    rd_valid = 4'b0010;
    rd_addr[1*AW +: AW] = 10'd5;
    @(negedge clk);
    chk("t1_grant", 32'(rd_ready), 32'h2);
    tick();
    chk("t1_rsp_before_rst", 32'(rsp_valid), 32'h2);
    reset = 1'b1;
    rd_valid = 4'b1111;
    wr_valid = 4'b1111;
    for (int i = 0; i < 4; i++) wr_addr[i*AW +: AW] = AW'(100 + i);
    #1;
    chk("t1_rsp_killed", 32'(rsp_valid), 0);
    chk("t1_rd_ready", 32'(rd_ready), 0);
    chk("t1_wr_ready", 32'(wr_ready), 0);
    chk("t1_re", 32'(spad_read_req), 0);
    chk("t1_we", 32'(spad_write_en), 0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    rd_valid = '0;
    wr_valid = '0;
    @(negedge clk);
    chk("t1_no_rsp_after", 32'(rsp_valid), 0);
    tick();

    // 2: round-robin fairness
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = AW'(i);
    rd_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_grant", 32'(rd_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        chk("t2_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 1) % 4)));
        chk("t2_rsp_data", 32'(rsp_data), 32'(16'h100 + (c - 1) % 4));
      end
      tick();
    end
    rd_valid = '0;
    @(negedge clk);
    chk("t2_rsp_valid_last", 32'(rsp_valid), 32'h8);
    chk("t2_rsp_data_last", 32'(rsp_data), 32'h103);
    tick();

    // 3: pointer hold
    rd_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_grant2", 32'(rd_ready), 32'h4);
      tick();
    end
    rd_valid = 4'b1111;
    @(negedge clk);
    chk("t3_grant3", 32'(rd_ready), 32'h8);
    tick();
    rd_valid = '0;

    // 4: write arbitration
    wr_addr[0*AW +: AW] = 10'd10; wr_data[0*DW +: DW] = 16'hAAAA;
    wr_addr[3*AW +: AW] = 10'd11; wr_data[3*DW +: DW] = 16'hBBBB;
    wr_valid = 4'b1001;
    @(negedge clk);
    chk("t4_wgrant0", 32'(wr_ready), 32'h1);
    tick();
    wr_valid = 4'b1000;
    @(negedge clk);
    chk("t4_wgrant3", 32'(wr_ready), 32'h8);
    tick();
    wr_valid = '0;
    do_read(0, 10, d);
    chk("t4_rd10", 32'(d), 32'hAAAA);
    do_read(0, 11, d);
    chk("t4_rd11", 32'(d), 32'hBBBB);

    // 5: same-address collision
    wr_addr[2*AW +: AW] = 10'd7; wr_data[2*DW +: DW] = 16'h2222;
    rd_addr[1*AW +: AW] = 10'd7;
    wr_valid = 4'b0100;
    rd_valid = 4'b0010;
    @(negedge clk);
    chk("t5_wr_ready", 32'(wr_ready), 32'h4);
`ifdef RAW_BYPASS_EN
    chk("t5_rd_ready_byp", 32'(rd_ready), 32'h2);
    chk("t5_re_byp", 32'(spad_read_req), 0);
    tick();
    wr_valid = '0;
    rd_valid = '0;
    @(negedge clk);
`else
    chk("t5_rd_stall", 32'(rd_ready), 0);
    chk("t5_re_stall", 32'(spad_read_req), 0);
    tick();
    wr_valid = '0;
    @(negedge clk);
    chk("t5_rd_retry", 32'(rd_ready), 32'h2);
    tick();
    rd_valid = '0;
    @(negedge clk);
`endif
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t5_rsp_data", 32'(rsp_data), 32'h2222);
    tick();

    // 6: idle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t6_re", 32'(spad_read_req), 0);
      chk("t6_we", 32'(spad_write_en), 0);
      chk("t6_rsp", 32'(rsp_valid), 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
